// File: rtl/rd_pntr_empty.sv
// Read-side pointer and status of the dual-clock FIFO: read pointer (binary/Gray),
// RAM read address/enable, and registered empty / almost-empty / fill-level / underflow.
module rd_pntr_empty #(
   parameter int AWIDTH       = 3,
   parameter int ALMOST_EMPTY = 2
) (
   input  logic              rd_clk_i,
   input  logic              aclr_i,
   input  logic              rd_req_i,
   input  logic [AWIDTH:0]   wr_pntr_gray_i,
   output logic [AWIDTH-1:0] rd_addr_o,
   output logic              rd_en_o,
   output logic              rd_valid_o,
   output logic [AWIDTH:0]   rd_pntr_gray_o,
   output logic              rd_empty_o,
   output logic              rd_almost_empty_o,
   output logic [AWIDTH:0]   rd_usedw_o,
   output logic              rd_underflow_o
);

   localparam logic [AWIDTH:0] LP_AE = (AWIDTH+1)'(ALMOST_EMPTY);

   logic [AWIDTH:0] r_rd_bin;
   logic [AWIDTH:0] r_rd_gray;
   logic            r_empty;
   logic            r_almost_empty;
   logic [AWIDTH:0] r_usedw;
   logic            r_valid;
   logic            r_underflow;

   logic            w_rd_acc;
   logic [AWIDTH:0] w_rd_bin_next;
   logic [AWIDTH:0] w_rd_gray_next;
   logic [AWIDTH:0] w_wr_bin;
   logic [AWIDTH:0] w_usedw_next;

   // Handshake: a request is accepted (rd_en_o high, address valid) in any cycle
   // where rd_req_i is high and the registered empty flag is low; data follows one cycle later.
   assign w_rd_acc       = rd_req_i & ~r_empty;
   assign w_rd_bin_next  = r_rd_bin + {{AWIDTH{1'b0}}, w_rd_acc};
   assign w_rd_gray_next = w_rd_bin_next ^ (w_rd_bin_next >> 1);
   assign w_usedw_next   = w_wr_bin - w_rd_bin_next;

   always_comb begin
      w_wr_bin         = '0;
      w_wr_bin[AWIDTH] = wr_pntr_gray_i[AWIDTH];
      for (int i = AWIDTH - 1; i >= 0; i--) begin
         w_wr_bin[i] = w_wr_bin[i+1] ^ wr_pntr_gray_i[i];
      end
   end

   // Status uses the lagging synchronized write pointer, so empty can only be late, never early.
   always_ff @(posedge rd_clk_i or negedge aclr_i) begin
      if (!aclr_i) begin
         r_rd_bin       <= '0;
         r_rd_gray      <= '0;
         r_empty        <= 1'b1;
         r_almost_empty <= 1'b1;
         r_usedw        <= '0;
         r_valid        <= 1'b0;
         r_underflow    <= 1'b0;
      end else begin
         r_rd_bin       <= w_rd_bin_next;
         r_rd_gray      <= w_rd_gray_next;
         r_empty        <= (w_rd_gray_next == wr_pntr_gray_i);
         r_almost_empty <= (w_usedw_next <= LP_AE);
         r_usedw        <= w_usedw_next;
         r_valid        <= w_rd_acc;
         r_underflow    <= rd_req_i & r_empty;
      end
   end

   assign rd_addr_o         = r_rd_bin[AWIDTH-1:0];
   assign rd_en_o           = w_rd_acc;
   assign rd_valid_o        = r_valid;
   assign rd_pntr_gray_o    = r_rd_gray;
   assign rd_empty_o        = r_empty;
   assign rd_almost_empty_o = r_almost_empty;
   assign rd_usedw_o        = r_usedw;
   assign rd_underflow_o    = r_underflow;

endmodule

// File: tb/tb_rd_pntr_empty.sv
// Bench for rd_pntr_empty: a FIFO-occupancy model predicts every cycle's outputs into a queue,
// and a negedge monitor pops and compares.
module tb_rd_pntr_empty;

   localparam int AW    = 3;
   localparam int DEPTH = 8;
   localparam int PMOD  = 16;
   localparam int AE    = 2;

   logic          clk = 1'b0;
   logic          aclr_n = 1'b0;
   logic          req = 1'b0;
   logic [AW:0]   wr_gray = '0;
   logic [AW-1:0] rd_addr;
   logic          rd_en, rd_valid, rd_empty, rd_ae, rd_under;
   logic [AW:0]   rd_gray, rd_usedw;

   rd_pntr_empty #(.AWIDTH(AW), .ALMOST_EMPTY(AE)) dut (
      .rd_clk_i          (clk),
      .aclr_i            (aclr_n),
      .rd_req_i          (req),
      .wr_pntr_gray_i    (wr_gray),
      .rd_addr_o         (rd_addr),
      .rd_en_o           (rd_en),
      .rd_valid_o        (rd_valid),
      .rd_pntr_gray_o    (rd_gray),
      .rd_empty_o        (rd_empty),
      .rd_almost_empty_o (rd_ae),
      .rd_usedw_o        (rd_usedw),
      .rd_underflow_o    (rd_under)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic          en;
      logic [AW-1:0] addr;
      logic          valid;
      logic [AW:0]   gray;
      logic          empty;
      logic          ae;
      logic [AW:0]   usedw;
      logic          under;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   // Model: read/write counts as plain integers, occupancy = their difference.
   int m_rd, m_wr, m_usedw, p_wr;
   bit m_empty, m_valid, m_under, m_ae, p_req;

   function automatic logic [AW:0] to_gray(input int b);
      logic [AW:0] v;
      v = b[AW:0];
      return v ^ (v >> 1);
   endfunction

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_rd = 0; m_wr = 0; m_usedw = 0; p_wr = 0;
      m_empty = 1; m_valid = 0; m_under = 0; m_ae = 1; p_req = 0;
   endtask

   task automatic step(input bit req_v, input int wr_v);
      bit   acc;
      int   wv;
      exp_t e;
      @(posedge clk); #1;
      acc     = p_req & ~m_empty;
      m_valid = acc;
      m_under = p_req & m_empty;
      m_rd    = (m_rd + int'(acc)) % PMOD;
      m_usedw = (p_wr - m_rd + PMOD) % PMOD;
      m_empty = (m_usedw == 0);
      m_ae    = (m_usedw <= AE);
      wv = wr_v % PMOD;
      if (((wv - m_rd + PMOD) % PMOD) <= DEPTH) m_wr = wv;
      req     = req_v;
      wr_gray = to_gray(m_wr);
      p_req   = req_v;
      p_wr    = m_wr;
      e.en    = req_v & ~m_empty;
      e.addr  = AW'(m_rd % DEPTH);
      e.valid = m_valid;
      e.gray  = to_gray(m_rd);
      e.empty = m_empty;
      e.ae    = m_ae;
      e.usedw = (AW+1)'(m_usedw);
      e.under = m_under;
      exp_q.push_back(e);
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      aclr_n  = 1'b0;
      req     = 1'b0;
      wr_gray = '0;
      #1;
      check("rst_empty", int'(rd_empty), 1);
      check("rst_ae", int'(rd_ae), 1);
      check("rst_usedw", int'(rd_usedw), 0);
      check("rst_gray", int'(rd_gray), 0);
      check("rst_addr", int'(rd_addr), 0);
      check("rst_valid", int'(rd_valid), 0);
      check("rst_under", int'(rd_under), 0);
      check("rst_en", int'(rd_en), 0);
      repeat (2) @(posedge clk);
      #1 aclr_n = 1'b1;
      model_reset();
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("rd_en", int'(rd_en), int'(e.en));
         if (e.en) check("rd_addr", int'(rd_addr), int'(e.addr));
         check("rd_valid", int'(rd_valid), int'(e.valid));
         check("rd_gray", int'(rd_gray), int'(e.gray));
         check("rd_empty", int'(rd_empty), int'(e.empty));
         check("rd_almost_empty", int'(rd_ae), int'(e.ae));
         check("rd_usedw", int'(rd_usedw), int'(e.usedw));
         check("rd_underflow", int'(rd_under), int'(e.under));
      end
   end

   initial begin
      model_reset();
      do_reset();
      // underflow on empty, pointer stays
      step(1, 0); step(0, 0); step(0, 0);
      // single word written then read
      step(0, 1); step(0, 1); step(1, 1); step(0, 1); step(0, 1);
      // full FIFO then drain six words
      do_reset();
      step(0, 8); step(0, 8);
      for (int i = 0; i < 6; i++) step(1, 8);
      step(0, 8); step(0, 8);
      // streaming through the pointer wrap
      for (int i = 0; i < 20; i++) step(1, m_wr + 1);
      // request held while writes trickle in from empty
      do_reset();
      for (int i = 0; i < 14; i++) step(1, m_wr + int'($urandom_range(0, 1)));
      // random phases with varying read/write bias
      for (int ph = 0; ph < 4; ph++) begin
         for (int i = 0; i < 150; i++) begin
            step($urandom_range(0, 3) < ph + 1, m_wr + int'($urandom_range(0, 3) >= ph));
         end
      end
      // reset in the middle of a burst with five words stored
      do_reset();
      step(0, 5); step(0, 5); step(1, 5); step(1, 5);
      do_reset();
      for (int i = 0; i < 3; i++) step(0, 0);
      @(negedge clk); #1;
      check("queue_drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rd_pntr_empty.md
Name: rd_pntr_empty

Overview:
Read-side pointer and status logic of the dual-clock FIFO, directly downstream of the write-to-read pointer synchronizer. Consumes the write pointer (Gray, already resynchronized into the read domain) and the read request. Maintains the binary/Gray read pointer, drives the RAM read address and generates registered empty, almost-empty, fill-level and underflow status. Exports the read Gray pointer for the read-to-write synchronizer.

Parameters:
AWIDTH, 3, RAM address width; FIFO depth = 2**AWIDTH; pointers are AWIDTH+1 bits.
ALMOST_EMPTY, 2, rd_almost_empty_o asserted when fill level <= this value; legal range 0..2**AWIDTH.

Ports:
rd_clk_i  input  1  read-domain clock, rising edge.
aclr_i  input  1  asynchronous active-low reset.
rd_req_i  input  1  read request from the consumer.
wr_pntr_gray_i  input  AWIDTH+1  write pointer in Gray code, synchronized to rd_clk_i.
rd_addr_o  output  AWIDTH  RAM read address.
rd_en_o  output  1  RAM read enable, high in the cycle a read is accepted.
rd_valid_o  output  1  one-cycle pulse, RAM output data valid.
rd_pntr_gray_o  output  AWIDTH+1  read pointer in Gray code, registered.
rd_empty_o  output  1  FIFO empty, registered.
rd_almost_empty_o  output  1  fill level <= ALMOST_EMPTY, registered.
rd_usedw_o  output  AWIDTH+1  words available to read, 0..2**AWIDTH, registered.
rd_underflow_o  output  1  one-cycle pulse on a request made while empty.

Behaviour:
- Single clock rd_clk_i; asynchronous active-low reset aclr_i; all state resets immediately when aclr_i = 0.
- Reset values: rd_bin = 0, rd_pntr_gray_o = 0, rd_addr_o = 0, rd_empty_o = 1, rd_almost_empty_o = 1, rd_usedw_o = 0, rd_en_o = 0, rd_valid_o = 0, rd_underflow_o = 0.
- Accept: rd_acc = rd_req_i & ~rd_empty_o (combinational). rd_en_o = rd_acc.
- Pointer: rd_bin_next = rd_bin + rd_acc, modulo 2**(AWIDTH+1). rd_gray_next = rd_bin_next ^ (rd_bin_next >> 1). Register both each cycle.
- rd_addr_o = rd_bin[AWIDTH-1:0]. The address for the accepted word is presented in the same cycle as rd_en_o.
- rd_valid_o is rd_acc delayed by one cycle, matching the one-cycle registered RAM read latency.
- Empty: rd_empty_o <= (rd_gray_next == wr_pntr_gray_i).
- Fill level:
  - wr_bin = Gray-to-binary of wr_pntr_gray_i (XOR prefix from the MSB down).
  - rd_usedw_o <= (wr_bin - rd_bin_next) modulo 2**(AWIDTH+1).
  - The value is 2**AWIDTH when the pointers differ only in the MSB (full).
- Almost-empty: rd_almost_empty_o <= (usedw_next <= ALMOST_EMPTY).
- Underflow: rd_underflow_o <= rd_req_i & rd_empty_o. The pointer does not move, and there is no rd_en_o or rd_valid_o.
- Simultaneous accepted read and write-pointer advance: status is computed from rd_bin_next and the current wr_pntr_gray_i. The result is conservative, because the synchronized write pointer lags, so empty may be reported late but never early.
- Wrap-around: the pointer wraps from 2**(AWIDTH+1)-1 to 0. The Gray sequence stays single-bit-change across the wrap.
- Reset mid-operation: all outputs return to reset values asynchronously. Any pending rd_valid_o is dropped.
- Only registers drive rd_pntr_gray_o, with no combinational path from rd_req_i, so it is safe to cross domains.

Test Plan:
- Reset with aclr_i = 0 -> rd_empty_o = 1, rd_almost_empty_o = 1, rd_usedw_o = 0, rd_pntr_gray_o = 4'b0000, rd_addr_o = 0. rd_req_i = 1 gives rd_underflow_o = 1 for one cycle, and the pointer stays 0.
- wr_pntr_gray_i 0 -> 4'b0001 -> next edge rd_empty_o = 0, rd_usedw_o = 1. Then rd_req_i for one cycle -> rd_en_o = 1 with rd_addr_o = 0, rd_valid_o = 1 the following cycle, rd_pntr_gray_o = 4'b0001, rd_empty_o = 1.
- wr_pntr_gray_i = 4'b1100 (binary 8) with rd pointer 0 -> rd_usedw_o = 8, rd_empty_o = 0, rd_almost_empty_o = 0. Read 6 words back-to-back -> rd_usedw_o steps 7..2, and rd_almost_empty_o rises when the value reaches 2.
- Continuous writes and reads for 20 words -> rd_pntr_gray_o follows the Gray sequence through 4'b1000 -> 4'b0000 at the wrap. rd_addr_o cycles 0..7, and no spurious empty or underflow occurs.
- rd_req_i held high while wr_pntr_gray_i advances by 1 per cycle -> one accept per available word. rd_empty_o toggles correctly, and rd_underflow_o pulses only in cycles where rd_empty_o = 1.
- aclr_i pulsed low mid-burst with usedw = 5 -> all outputs return to reset values immediately, with no rd_valid_o after release.
